mmio_uart_tx: RTL



---
 rtl/mmio_uart_tx.sv | 286 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: memory-mapped 8N1 UART transmitter for the CPU bus.
//
// Register window (4 bytes at BASE_ADDR):
//   +0 DATA   write: push byte into TX FIFO (dropped when full); read: 8'h00
//   +1 STATUS read-only: {3'b0, irq_enable, overflow, fifo_empty, fifo_full, busy}
//   +2 CTRL   write: clears sticky overflow; read: 8'h00
//   +3 reserved, reads 8'h00, writes ignored
// Reads are registered: a hit read strobe loads mem_data_out and raises mem_sel
// for exactly one cycle on the following edge.
//
// Optional feature macro: MMIO_UART_TX_IRQ_EN
//   Adds output irq and CTRL bit0 irq_enable (also visible as STATUS bit4).
//   irq is registered: irq_enable && fifo_empty && shifter idle.
//
// Parameter constraints: BASE_ADDR[1:0] == 0, CLKS_PER_BIT >= 2,
// FIFO_DEPTH a power of 2 and >= 2.
module mmio_uart_tx #(
  parameter logic [15:0] BASE_ADDR    = 16'hE000,
  parameter int          CLKS_PER_BIT = 868,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] mem_address,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [7:0]  mem_data_in,
  output logic [7:0]  mem_data_out,
  output logic        mem_sel,
  output logic        uart_tx
`ifdef MMIO_UART_TX_IRQ_EN
  ,
  output logic        irq
`endif
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  FIFO_LIMIT = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_CTRL   = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Bus decode
  // ---------------------------------------------------------------------------
  logic       hit;
  logic [1:0] offset;
  logic       wr_data;
  logic       wr_ctrl;
  logic       rd_hit;

  assign hit     = (mem_address[15:2] == BASE_ADDR[15:2]);
  assign offset  = mem_address[1:0];
  assign wr_data = mem_write && hit && (offset == OFF_DATA);
  assign wr_ctrl = mem_write && hit && (offset == OFF_CTRL);
  assign rd_hit  = mem_read && hit;

  // ---------------------------------------------------------------------------
  // TX FIFO: circular buffer, power-of-2 depth so pointers wrap naturally
  // ---------------------------------------------------------------------------
  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  logic             drop;
  logic             overflow;

  state_t           state_q;
  state_t           state_d;

  assign fifo_full  = (count == FIFO_LIMIT);
  assign fifo_empty = (count == '0);
  // The shifter consumes the head byte on its IDLE->START transition.
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push       = wr_data && (!fifo_full || pop);
  assign drop       = wr_data && fifo_full && !pop;

  // FIFO storage write port.
  // NOTE: the data array has no reset; only pointers and count define which
  // entries are valid, so clearing the storage would add logic for nothing.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= mem_data_in;
    end
  end

  // FIFO pointers and occupancy count.
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every flop samples the pre-edge values of its peers.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Sticky overflow: set on a dropped write, cleared by any CTRL write.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (wr_ctrl) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional interrupt
  // ---------------------------------------------------------------------------
  logic irq_en_bit;

`ifdef MMIO_UART_TX_IRQ_EN
  logic irq_enable;

  // CTRL bit0 holds the interrupt enable.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq_enable <= 1'b0;
    end else if (wr_ctrl) begin
      irq_enable <= mem_data_in[0];
    end
  end

  // Registered "transmitter drained" interrupt.
  always_ff @(posedge clk) begin
    if (reset) begin
      irq <= 1'b0;
    end else begin
      irq <= irq_enable && fifo_empty && (state_q == ST_IDLE);
    end
  end

  assign irq_en_bit = irq_enable;
`else
  assign irq_en_bit = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Register read path
  // ---------------------------------------------------------------------------
  logic       busy;
  logic [7:0] status;
  logic [7:0] rd_mux;

  assign busy   = (state_q != ST_IDLE);
  assign status = {3'b000, irq_en_bit, overflow, fifo_empty, fifo_full, busy};

  // Select read data by offset; only STATUS returns non-zero content.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    rd_mux = 8'h00;
    if (offset == OFF_STATUS) begin
      rd_mux = status;
    end
  end

  // One-cycle registered read response; data holds until the next hit read.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_data_out <= 8'h00;
      mem_sel      <= 1'b0;
    end else begin
      mem_sel <= rd_hit;
      if (rd_hit) begin
        mem_data_out <= rd_mux;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Serial shifter FSM
  // ---------------------------------------------------------------------------
  logic [BAUD_W-1:0] baud_cnt;
  logic [2:0]        bit_idx;
  logic [7:0]        shift;
  logic              baud_done;

  assign baud_done = (baud_cnt == BAUD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: each non-idle state lasts CLKS_PER_BIT cycles per bit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (!fifo_empty)                   state_d = ST_START;
      ST_START: if (baud_done)                     state_d = ST_DATA;
      ST_DATA:  if (baud_done && bit_idx == 3'd7)  state_d = ST_STOP;
      ST_STOP:  if (baud_done)                     state_d = ST_IDLE;
      default:                                     state_d = ST_IDLE;
    endcase
  end

  // Baud counter, bit index and shift register advance with the FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= 8'h00;
    end else begin
      case (state_q)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
          if (pop) begin
            shift <= fifo_mem[rd_ptr];
          end
        end
        ST_START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= bit_idx + 3'd1;
            shift    <= {1'b0, shift[7:1]};
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        ST_STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
          end else begin
            baud_cnt <= baud_cnt + BAUD_W'(1);
          end
        end
        default: begin
          baud_cnt <= '0;
          bit_idx  <= '0;
        end
      endcase
    end
  end

  // Line level decoded from registered state: low start bit, LSB-first data.
  always_comb begin
    uart_tx = 1'b1;
    case (state_q)
      ST_START: uart_tx = 1'b0;
      ST_DATA:  uart_tx = shift[0];
      default:  uart_tx = 1'b1;
    endcase
  end

endmodule
